clint_mh: RTL and testbench

- Parametrised core-local interruptor for NPC: one shared 64-bit mtime, per-hart mtimecmp and msip registers.
- Exposed through a valid/ready memory-mapped register port at the standard CLINT offsets.
- Replaces DPI-backed timer access with on-chip registers and adds a tick prescaler, multi-hart support and software interrupts.
- Emits raw pending bits, plus interrupt requests gated by the per-hart enable bits from the CSR file.

---
 rtl/clint_mh.sv | 165 ++++++++++++++++
 tb/tb_clint_mh.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_mh.sv
// Core-local interruptor: one shared 64-bit mtime with a tick prescaler, per-hart mtimecmp and
// msip registers behind a single-outstanding valid/ready register port at the CLINT offsets.
module clint_mh #(
   parameter int unsigned NHART    = 1,
   parameter logic [31:0] BASE     = 32'h0200_0000,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [63:0]      req_wdata,
   input  logic [7:0]       req_wmask,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_rdata,
   output logic             rsp_err,
   input  logic             mie,
   input  logic [NHART-1:0] mtie,
   input  logic [NHART-1:0] msie,
   output logic [NHART-1:0] mtip,
   output logic [NHART-1:0] msip_o,
   output logic [NHART-1:0] tint,
   output logic [NHART-1:0] sint
);

   localparam int unsigned   PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
   localparam logic [28:0]   MSIP_DWS    = 29'((NHART + 1) / 2);
   localparam logic [28:0]   MTIMECMP_DW = 29'h0800;
   localparam logic [28:0]   MTIME_DW    = 29'h17FF;

   typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} sel_e;

   generate
      if (NHART < 1 || NHART > 8 || TICK_DIV < 1) begin : g_bad_param
         $error("clint_mh: NHART must be 1..8 and TICK_DIV must be >= 1");
      end
   endgenerate

   logic [63:0]      mtime, mtime_next;
   logic [63:0]      mtimecmp      [NHART];
   logic [63:0]      mtimecmp_next [NHART];
   logic [NHART-1:0] msip, msip_next;
   logic [NHART-1:0] mtip_next;
   logic [PW-1:0]    presc, presc_next;
   logic             tick;

   logic [28:0]      dw, idx;
   sel_e             sel;
   logic             accept, wr, wr_mtime;
   logic [63:0]      rd_data;
   logic             unused_addr_lsb;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] m);
      logic [63:0] res;
      for (int b = 0; b < 8; b++) res[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
      return res;
   endfunction

   // Doubleword index relative to BASE; the byte offset inside a doubleword is ignored.
   assign dw              = req_addr[31:3] - BASE[31:3];
   assign unused_addr_lsb = ^req_addr[2:0];

   // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      sel = SEL_NONE;
      idx = '0;
      if (dw < MSIP_DWS) begin
         sel = SEL_MSIP;
         idx = dw;
      end else if (dw >= MTIMECMP_DW && dw < MTIMECMP_DW + 29'(NHART)) begin
         sel = SEL_MTIMECMP;
         idx = dw - MTIMECMP_DW;
      end else if (dw == MTIME_DW) begin
         sel = SEL_MTIME;
      end
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         SEL_MSIP: begin
            for (int h = 0; h < NHART; h++) begin
               if (idx == 29'(h / 2)) begin
                  if (h % 2 == 0) rd_data[0]  = msip[h];
                  else            rd_data[32] = msip[h];
               end
            end
         end
         SEL_MTIMECMP: begin
            for (int h = 0; h < NHART; h++) begin
               if (idx == 29'(h)) rd_data = mtimecmp[h];
            end
         end
         SEL_MTIME: rd_data = mtime;
         default:   rd_data = '0;
      endcase
   end

   assign req_ready  = !rsp_valid || rsp_ready;
   assign accept     = req_valid && req_ready;
   assign wr         = accept && req_we;
   assign wr_mtime   = wr && (sel == SEL_MTIME) && (|req_wmask);
   assign tick       = (presc == PRESC_MAX);
   assign presc_next = tick ? '0 : presc + PW'(1);

   // A bus write to mtime overrides the tick; the prescaler keeps running regardless.
   always_comb begin
      mtime_next = tick ? mtime + 64'd1 : mtime;
      if (wr_mtime) mtime_next = merge(mtime, req_wdata, req_wmask);
      msip_next = msip;
      for (int h = 0; h < NHART; h++) begin
         mtimecmp_next[h] = mtimecmp[h];
         if (wr && sel == SEL_MTIMECMP && idx == 29'(h))
            mtimecmp_next[h] = merge(mtimecmp[h], req_wdata, req_wmask);
         if (wr && sel == SEL_MSIP && idx == 29'(h / 2)) begin
            if (h % 2 == 0 && req_wmask[0]) msip_next[h] = req_wdata[0];
            if (h % 2 == 1 && req_wmask[4]) msip_next[h] = req_wdata[32];
         end
         mtip_next[h] = (mtime_next >= mtimecmp_next[h]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: mtimecmp is a small register array, not a RAM, so each entry takes its reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime <= '0;
         presc <= '0;
         msip  <= '0;
         mtip  <= '0;
         for (int h = 0; h < NHART; h++) mtimecmp[h] <= '1;
      end else begin
         mtime <= mtime_next;
         presc <= presc_next;
         msip  <= msip_next;
         mtip  <= mtip_next;
         for (int h = 0; h < NHART; h++) mtimecmp[h] <= mtimecmp_next[h];
      end
   end

   // Response holds data and error until consumed; reads see pre-edge register values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= req_we ? 64'd0 : rd_data;
         rsp_err   <= (sel == SEL_NONE);
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign msip_o = msip;
   assign tint   = mtip & mtie & {NHART{mie}};
   assign sint   = msip & msie & {NHART{mie}};

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: a 2-hart instance at TICK_DIV=1 and a 1-hart instance at
// TICK_DIV=4 share the request bus; each has its own req_valid.
module tb_clint_mh;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        va, vb;
   logic        req_we;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        rsp_ready;
   logic        mie;

   logic        ready_a, rsp_valid_a, err_a;
   logic [63:0] rdata_a;
   logic [1:0]  mtie_a, msie_a, mtip_a, msip_o_a, tint_a, sint_a;

   logic        ready_b, rsp_valid_b, err_b;
   logic [63:0] rdata_b;
   logic [0:0]  mtie_b, msie_b, mtip_b, msip_o_b, tint_b, sint_b;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [63:0] rd;
   logic        er;

   always #5 clk = ~clk;

   always @(posedge clk) if (rst) cyc <= cyc + 1;

   clint_mh #(.NHART(2), .BASE(BASE), .TICK_DIV(1)) u_a (
      .clk(clk), .rst(rst), .req_valid(va), .req_ready(ready_a), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a),
      .mie(mie), .mtie(mtie_a), .msie(msie_a), .mtip(mtip_a), .msip_o(msip_o_a),
      .tint(tint_a), .sint(sint_a)
   );

   clint_mh #(.NHART(1), .BASE(BASE), .TICK_DIV(4)) u_b (
      .clk(clk), .rst(rst), .req_valid(vb), .req_ready(ready_b), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b),
      .mie(mie), .mtie(mtie_b), .msie(msie_b), .mtip(mtip_b), .msip_o(msip_o_b),
      .tint(tint_b), .sint(sint_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called with clk low; returns at the negedge after the accepting posedge.
   task automatic xact(input bit use_b, input bit we, input logic [31:0] off,
                       input logic [63:0] wd, input logic [7:0] wm,
                       output logic [63:0] rdo, output logic ero);
      int waited = 0;
      req_we    = we;
      req_addr  = BASE + off;
      req_wdata = wd;
      req_wmask = wm;
      rsp_ready = 1'b1;
      if (use_b) vb = 1'b1; else va = 1'b1;
      #1;
      while (!(use_b ? ready_b : ready_a) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("req_ready", use_b ? ready_b : ready_a, 1'b1);
      @(negedge clk);
      va = 1'b0;
      vb = 1'b0;
      check("rsp_valid", use_b ? rsp_valid_b : rsp_valid_a, 1'b1);
      rdo = use_b ? rdata_b : rdata_a;
      ero = use_b ? err_b : err_a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; va = 1'b0; vb = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1; mie = 1'b1;
      mtie_a = 2'b11; msie_a = 2'b11; mtie_b = 1'b1; msie_b = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_req_ready", ready_a, 1'b1);
      check("rst_rsp_valid", rsp_valid_a, 1'b0);
      check("rst_rsp_rdata", rdata_a, 64'd0);
      check("rst_rsp_err", err_a, 1'b0);
      check("rst_mtip", mtip_a, 2'b00);
      check("rst_msip_o", msip_o_a, 2'b00);
      check("rst_tint", tint_a, 2'b00);
      check("rst_sint", sint_a, 2'b00);
      check("rst_b_ready", ready_b, 1'b1);
      rst = 1'b1;

      // Free-running mtime and reset mtimecmp
      repeat (9) @(negedge clk);
      xact(0, 0, 32'hBFF8, 64'd0, 8'h00, rd, er);
      check("mtime_at_10", rd, 64'd9);
      check("mtime_err", er, 1'b0);
      xact(0, 0, 32'h4000, 64'd0, 8'h00, rd, er);
      check("mtimecmp0_rst", rd, 64'hFFFF_FFFF_FFFF_FFFF);

      // Timer compare
      xact(0, 1, 32'h4000, 64'h20, 8'hFF, rd, er);
      check("wr_rdata_zero", rd, 64'd0);
      check("wr_err", er, 1'b0);
      xact(0, 1, 32'hBFF8, 64'h1E, 8'hFF, rd, er);
      check("mtip_at_1e", mtip_a, 2'b00);
      @(negedge clk);
      check("mtip_at_1f", mtip_a, 2'b00);
      @(negedge clk);
      check("mtip_at_20", mtip_a, 2'b01);
      check("tint_at_20", tint_a, 2'b01);
      mtie_a = 2'b10;
      #1 check("tint_mtie_off", tint_a, 2'b00);
      mtie_a = 2'b11;
      @(negedge clk);
      check("mtip_level", mtip_a, 2'b01);
      xact(0, 1, 32'h4000, 64'h100, 8'hFF, rd, er);
      check("mtip_cmp_raised", mtip_a, 2'b00);
      check("tint_cmp_raised", tint_a, 2'b00);

      // Software interrupts
      xact(0, 1, 32'h0000, 64'h0000_0001_0000_0000, 8'hF0, rd, er);
      check("msip_hi_only", msip_o_a, 2'b10);
      check("sint_hi", sint_a, 2'b10);
      msie_a = 2'b01;
      #1 check("sint_msie_off", sint_a, 2'b00);
      msie_a = 2'b11;
      mie = 1'b0;
      #1 check("sint_mie_off", sint_a, 2'b00);
      mie = 1'b1;
      xact(0, 0, 32'h0000, 64'd0, 8'h00, rd, er);
      check("msip_read", rd, 64'h0000_0001_0000_0000);
      xact(0, 1, 32'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, er);
      xact(0, 0, 32'h0004, 64'd0, 8'h00, rd, er);
      check("msip_read_both", rd, 64'h0000_0001_0000_0001);
      xact(0, 1, 32'h0000, 64'd0, 8'h00, rd, er);
      check("wmask0_err", er, 1'b0);
      check("wmask0_noop", msip_o_a, 2'b11);

      // Unmapped addresses and byte masking
      xact(0, 0, 32'h8000, 64'd0, 8'h00, rd, er);
      check("hole_rdata", rd, 64'd0);
      check("hole_err", er, 1'b1);
      xact(0, 0, 32'h4010, 64'd0, 8'h00, rd, er);
      check("cmp_oob_rdata", rd, 64'd0);
      check("cmp_oob_err", er, 1'b1);
      xact(0, 1, 32'h4010, 64'd0, 8'hFF, rd, er);
      check("cmp_oob_wr_err", er, 1'b1);
      xact(0, 0, 32'h0008, 64'd0, 8'h00, rd, er);
      check("msip_oob_err", er, 1'b1);
      xact(0, 1, 32'h4008, 64'h0000_0000_0000_00AB, 8'h01, rd, er);
      xact(0, 0, 32'h4008, 64'd0, 8'h00, rd, er);
      check("cmp1_bytemask", rd, 64'hFFFF_FFFF_FFFF_FFAB);
      check("cmp1_err", er, 1'b0);

      // Backpressure and back-to-back request
      @(negedge clk);
      req_we = 1'b0; req_addr = BASE + 32'h4000; rsp_ready = 1'b0; va = 1'b1;
      @(negedge clk);
      va = 1'b0;
      check("bp_rsp_valid", rsp_valid_a, 1'b1);
      check("bp_rdata_0", rdata_a, 64'h100);
      check("bp_ready_0", ready_a, 1'b0);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         check("bp_rdata_hold", rdata_a, 64'h100);
         check("bp_ready_low", ready_a, 1'b0);
      end
      rsp_ready = 1'b1; req_addr = BASE + 32'h4008; va = 1'b1;
      #1 check("b2b_ready", ready_a, 1'b1);
      @(negedge clk);
      va = 1'b0;
      check("b2b_rsp_valid", rsp_valid_a, 1'b1);
      check("b2b_rdata", rdata_a, 64'hFFFF_FFFF_FFFF_FFAB);
      @(negedge clk);
      check("b2b_drained", rsp_valid_a, 1'b0);

      // Prescaler, wrap-around and write/tick collision on the TICK_DIV=4 instance
      begin
         int e;
         e = cyc;
         xact(1, 0, 32'hBFF8, 64'd0, 8'h00, rd, er);
         check("b_mtime_div4", rd, 64'(e / 4));
      end
      while (cyc % 4 != 3) @(negedge clk);
      xact(1, 1, 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
      xact(1, 0, 32'hBFF8, 64'd0, 8'h00, rd, er);
      check("b_wr_on_tick", rd, 64'hFFFF_FFFF_FFFF_FFFE);
      repeat (6) @(negedge clk);
      check("b_mtip_max", mtip_b, 1'b1);
      check("b_tint_max", tint_b, 1'b1);
      xact(1, 0, 32'hBFF8, 64'd0, 8'h00, rd, er);
      check("b_mtime_max", rd, 64'hFFFF_FFFF_FFFF_FFFF);
      check("b_mtip_wrapped", mtip_b, 1'b0);
      xact(1, 0, 32'hBFF8, 64'd0, 8'h00, rd, er);
      check("b_mtime_wrap0", rd, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
